// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration stream loader.
package cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ADDR,
    ST_DATA,
    ST_CHECK,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } cfg_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] END_ADDR  = 8'hFF;

  localparam int TILE_BYTES = 5;
  localparam int SB_BYTES   = 2;

  localparam logic [1:0] ERR_ADDR       = 2'd1;
  localparam logic [1:0] ERR_CSUM       = 2'd2;
  localparam logic [1:0] ERR_INCOMPLETE = 2'd3;

endpackage

// File: rtl/cfg_byte_assembler.sv
// Byte-serial word assembler: 40-bit right-shifting register, byte counter
// and running XOR checksum, all restartable with clr.
module cfg_byte_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  din,
  output logic [39:0] shreg,
  output logic [2:0]  count,
  output logic [7:0]  csum
);

  logic [39:0] shreg_q, shreg_d, shreg_base;
  logic [2:0]  count_q, count_d, count_base;
  logic [7:0]  csum_q,  csum_d,  csum_base;

  // clr and load may coincide: the loaded byte starts a fresh frame.
  always_comb begin
    shreg_base = clr ? '0 : shreg_q;
    count_base = clr ? '0 : count_q;
    csum_base  = clr ? '0 : csum_q;
    shreg_d    = shreg_base;
    count_d    = count_base;
    csum_d     = csum_base;
    if (load) begin
      shreg_d = {din, shreg_base[39:8]};
      count_d = count_base + 3'd1;
      csum_d  = csum_base ^ din;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      count_q <= '0;
      csum_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
      csum_q  <= csum_d;
    end
  end

  assign shreg = shreg_q;
  assign count = count_q;
  assign csum  = csum_q;

endmodule

// File: rtl/cfg_stream_loader.sv
// Framed, checksummed configuration loader writing tile and switch-box words
// through one write port; fabric_en rises only after a complete clean load.
module cfg_stream_loader #(
  parameter int         NUM_TILES = 9,
  parameter int         NUM_SB    = 13,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] END_ADDR  = 8'hFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        cfg_we,
  output logic [4:0]  cfg_addr,
  output logic [32:0] cfg_data,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [1:0]  err_code,
  output logic        fabric_en
);
  import cfg_pkg::*;

  localparam int         NUM_CFG  = NUM_TILES + NUM_SB;
  localparam logic [7:0] TILE_LIM = 8'(NUM_TILES);
  localparam logic [7:0] SB_LIM   = 8'(NUM_CFG);

  cfg_state_t           state_q, state_d;
  logic                 is_tile_q, is_tile_d;
  logic [4:0]           frame_addr_q, frame_addr_d;
  logic [NUM_CFG-1:0]   mask_q, mask_d;
  logic                 cfg_we_q, cfg_we_d;
  logic [4:0]           cfg_addr_q, cfg_addr_d;
  logic [32:0]          cfg_data_q, cfg_data_d;
  logic                 cfg_done_q, cfg_done_d;
  logic                 cfg_error_q, cfg_error_d;
  logic [1:0]           err_code_q, err_code_d;
  logic                 fabric_en_q, fabric_en_d;

  logic        xfer, asm_clr, asm_load;
  logic [39:0] shreg;
  logic [2:0]  count, last_cnt;
  logic [7:0]  csum;
  logic [32:0] word;

  cfg_byte_assembler u_asm (
    .clock (clock),
    .reset (reset),
    .clr   (asm_clr),
    .load  (asm_load),
    .din   (din),
    .shreg (shreg),
    .count (count),
    .csum  (csum)
  );

  // The address byte is loaded too, so count includes it and the checksum
  // covers it; after the last data byte the word sits at the top of shreg.
  assign last_cnt = is_tile_q ? 3'(TILE_BYTES) : 3'(SB_BYTES);
  assign word     = is_tile_q ? shreg[32:0] : {17'b0, shreg[39:24]};
  assign din_ready = (state_q == ST_SYNC) || (state_q == ST_ADDR) ||
                     (state_q == ST_DATA) || (state_q == ST_CHECK);
  assign xfer = din_valid && din_ready && !start;

  always_comb begin
    state_d      = state_q;
    is_tile_d    = is_tile_q;
    frame_addr_d = frame_addr_q;
    mask_d       = mask_q;
    cfg_we_d     = 1'b0;
    cfg_addr_d   = cfg_addr_q;
    cfg_data_d   = cfg_data_q;
    cfg_done_d   = cfg_done_q;
    cfg_error_d  = cfg_error_q;
    err_code_d   = err_code_q;
    asm_clr      = 1'b0;
    asm_load     = 1'b0;
    if (start) begin
      state_d     = ST_SYNC;
      mask_d      = '0;
      cfg_done_d  = 1'b0;
      cfg_error_d = 1'b0;
      err_code_d  = 2'd0;
      asm_clr     = 1'b1;
    end else begin
      case (state_q)
        ST_SYNC: if (xfer && din == SYNC_BYTE) state_d = ST_ADDR;
        ST_ADDR: if (xfer) begin
          asm_clr      = 1'b1;
          asm_load     = 1'b1;
          frame_addr_d = din[4:0];
          if (din < TILE_LIM) begin
            is_tile_d = 1'b1;
            state_d   = ST_DATA;
          end else if (din < SB_LIM) begin
            is_tile_d = 1'b0;
            state_d   = ST_DATA;
          end else if (din == END_ADDR && &mask_q) begin
            cfg_done_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            cfg_error_d = 1'b1;
            err_code_d  = (din == END_ADDR) ? ERR_INCOMPLETE : ERR_ADDR;
            state_d     = ST_ERROR;
          end
        end
        ST_DATA: if (xfer) begin
          asm_load = 1'b1;
          if (count == last_cnt) state_d = ST_CHECK;
        end
        ST_CHECK: if (xfer) begin
          if (din == csum) begin
            cfg_we_d             = 1'b1;
            cfg_addr_d           = frame_addr_q;
            cfg_data_d           = word;
            mask_d[frame_addr_q] = 1'b1;
            state_d              = ST_WRITE;
          end else begin
            cfg_error_d = 1'b1;
            err_code_d  = ERR_CSUM;
            state_d     = ST_ERROR;
          end
        end
        ST_WRITE: state_d = ST_ADDR;
        default: ;
      endcase
    end
    fabric_en_d = cfg_done_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      is_tile_q    <= 1'b0;
      frame_addr_q <= '0;
      mask_q       <= '0;
      cfg_we_q     <= 1'b0;
      cfg_addr_q   <= '0;
      cfg_data_q   <= '0;
      cfg_done_q   <= 1'b0;
      cfg_error_q  <= 1'b0;
      err_code_q   <= '0;
      fabric_en_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_tile_q    <= is_tile_d;
      frame_addr_q <= frame_addr_d;
      mask_q       <= mask_d;
      cfg_we_q     <= cfg_we_d;
      cfg_addr_q   <= cfg_addr_d;
      cfg_data_q   <= cfg_data_d;
      cfg_done_q   <= cfg_done_d;
      cfg_error_q  <= cfg_error_d;
      err_code_q   <= err_code_d;
      fabric_en_q  <= fabric_en_d;
    end
  end

  assign cfg_we    = cfg_we_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign cfg_done  = cfg_done_q;
  assign cfg_error = cfg_error_q;
  assign err_code  = err_code_q;
  assign fabric_en = fabric_en_q;

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed bench for cfg_stream_loader: full loads, framing/checksum errors,
// gapped input, reset and restart behaviour.
module tb_cfg_stream_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [32:0] cfg_data;
  logic        cfg_done;
  logic        cfg_error;
  logic [1:0]  err_code;
  logic        fabric_en;

  int n_total = 0;
  int n_bad   = 0;
  logic gap_mode = 1'b0;

  logic [4:0]  wr_addr [0:127];
  logic [32:0] wr_data [0:127];
  int          wr_cnt = 0;

  cfg_stream_loader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error),
    .err_code  (err_code),
    .fabric_en (fabric_en)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (cfg_we) begin
      if (wr_cnt < 128) begin
        wr_addr[wr_cnt] <= cfg_addr;
        wr_data[wr_cnt] <= cfg_data;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame payload model: tiles get a+1..a+4 plus a b4 with junk upper bits,
  // switch boxes get 34+k / 12^k (k = a-9).
  function automatic logic [7:0] fb(input int a, input int i);
    logic [7:0] av;
    av = 8'(a);
    if (a < 9) begin
      case (i)
        0: return av + 8'd1;
        1: return av + 8'd2;
        2: return av + 8'd3;
        3: return av + 8'd4;
        default: return {3'b000, av[3:0], ~av[0]};
      endcase
    end
    if (i == 0) return 8'h34 + (av - 8'd9);
    return 8'h12 ^ (av - 8'd9);
  endfunction

  function automatic int nb(input int a);
    return (a < 9) ? 5 : 2;
  endfunction

  function automatic logic [32:0] exp_word(input int a);
    logic [7:0] b4;
    if (a < 9) begin
      b4 = fb(a, 4);
      return {b4[0], fb(a, 3), fb(a, 2), fb(a, 1), fb(a, 0)};
    end
    return {17'b0, fb(a, 1), fb(a, 0)};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gap_mode) repeat ($urandom_range(1, 3)) begin @(posedge clock); #1; end
    din = b;
    din_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (!din_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!din_ready) chk("ready_timeout", 64'd0, 64'd1);
    else begin
      @(posedge clock);
      #1;
    end
    din_valid = 1'b0;
  endtask

  task automatic send_frame(input int a, input logic bad_csum);
    logic [7:0] cs;
    cs = 8'(a);
    send_byte(8'(a));
    for (int i = 0; i < nb(a); i++) begin
      send_byte(fb(a, i));
      cs = cs ^ fb(a, i);
    end
    send_byte(bad_csum ? 8'h00 : cs);
  endtask

  task automatic pulse_start(input logic with_byte, input logic [7:0] b);
    start = 1'b1;
    if (with_byte) begin
      din = b;
      din_valid = 1'b1;
    end
    @(posedge clock);
    #1;
    start = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic send_frames(input int last);
    for (int a = 0; a <= last; a++) send_frame(a, 1'b0);
  endtask

  task automatic check_writes(input string tag, input int base, input int cnt);
    chk({tag, "_count"}, 64'(wr_cnt - base), 64'(cnt));
    for (int i = 0; i < cnt; i++) begin
      chk({tag, "_addr"}, 64'(wr_addr[base + i]), 64'(i));
      chk({tag, "_data"}, 64'(wr_data[base + i]), 64'(exp_word(i)));
    end
  endtask

  initial begin
    int base;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", 64'(din_ready), 64'd0);
    chk("rst_we", 64'(cfg_we), 64'd0);
    chk("rst_addr", 64'(cfg_addr), 64'd0);
    chk("rst_data", 64'(cfg_data), 64'd0);
    chk("rst_done", 64'(cfg_done), 64'd0);
    chk("rst_error", 64'(cfg_error), 64'd0);
    chk("rst_code", 64'(err_code), 64'd0);
    chk("rst_fen", 64'(fabric_en), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("idle_ready", 64'(din_ready), 64'd0);

    // Full stream with noise before sync
    base = wr_cnt;
    pulse_start(1'b0, 8'h00);
    chk("sync_ready", 64'(din_ready), 64'd1);
    send_byte(8'h00);
    send_byte(8'h3C);
    send_byte(8'hA5);
    send_frame(0, 1'b0);
    chk("t0_we", 64'(cfg_we), 64'd1);
    chk("t0_we_ready", 64'(din_ready), 64'd0);
    chk("t0_addr", 64'(cfg_addr), 64'd0);
    chk("t0_data", 64'(cfg_data), 64'h1_0403_0201);
    for (int a = 1; a <= 21; a++) send_frame(a, 1'b0);
    chk("full_pre_done", 64'(cfg_done), 64'd0);
    send_byte(8'hFF);
    chk("full_done", 64'(cfg_done), 64'd1);
    chk("full_fen", 64'(fabric_en), 64'd1);
    chk("full_err", 64'(cfg_error), 64'd0);
    chk("full_ready", 64'(din_ready), 64'd0);
    chk("full_hold_addr", 64'(cfg_addr), 64'd21);
    @(posedge clock);
    #1;
    check_writes("full", base, 22);

    // Checksum error on frame 9
    base = wr_cnt;
    pulse_start(1'b0, 8'h00);
    chk("restart_done", 64'(cfg_done), 64'd0);
    chk("restart_fen", 64'(fabric_en), 64'd0);
    send_byte(8'hA5);
    send_frames(8);
    send_frame(9, 1'b1);
    chk("csum_err", 64'(cfg_error), 64'd1);
    chk("csum_code", 64'(err_code), 64'd2);
    chk("csum_ready", 64'(din_ready), 64'd0);
    chk("csum_done", 64'(cfg_done), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("csum_writes", 64'(wr_cnt - base), 64'd9);
    chk("csum_last_addr", 64'(wr_addr[wr_cnt - 1]), 64'd8);

    // Bad address
    base = wr_cnt;
    pulse_start(1'b0, 8'h00);
    chk("err_cleared", 64'(cfg_error), 64'd0);
    send_byte(8'hA5);
    send_byte(8'h30);
    chk("badaddr_err", 64'(cfg_error), 64'd1);
    chk("badaddr_code", 64'(err_code), 64'd1);
    @(posedge clock);
    #1;
    chk("badaddr_writes", 64'(wr_cnt - base), 64'd0);

    // Incomplete load
    base = wr_cnt;
    pulse_start(1'b0, 8'h00);
    send_byte(8'hA5);
    send_frames(20);
    send_byte(8'hFF);
    chk("incomp_err", 64'(cfg_error), 64'd1);
    chk("incomp_code", 64'(err_code), 64'd3);
    chk("incomp_fen", 64'(fabric_en), 64'd0);
    chk("incomp_done", 64'(cfg_done), 64'd0);
    @(posedge clock);
    #1;
    chk("incomp_writes", 64'(wr_cnt - base), 64'd21);

    // Gapped input
    base = wr_cnt;
    gap_mode = 1'b1;
    pulse_start(1'b0, 8'h00);
    send_byte(8'h3C);
    send_byte(8'hA5);
    send_frames(21);
    send_byte(8'hFF);
    gap_mode = 1'b0;
    chk("gap_done", 64'(cfg_done), 64'd1);
    chk("gap_fen", 64'(fabric_en), 64'd1);
    chk("gap_err", 64'(cfg_error), 64'd0);
    @(posedge clock);
    #1;
    check_writes("gap", base, 22);

    // Reset while cfg_we is high, then mid-tile-frame
    pulse_start(1'b0, 8'h00);
    send_byte(8'hA5);
    send_frame(0, 1'b0);
    chk("prerst_we", 64'(cfg_we), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_we_async", 64'(cfg_we), 64'd0);
    chk("rst_data_async", 64'(cfg_data), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    pulse_start(1'b0, 8'h00);
    send_byte(8'hA5);
    send_frames(2);
    send_byte(8'h03);
    send_byte(fb(3, 0));
    send_byte(fb(3, 1));
    #1 reset = 1'b1;
    #1;
    chk("midrst_addr", 64'(cfg_addr), 64'd0);
    chk("midrst_data", 64'(cfg_data), 64'd0);
    chk("midrst_ready", 64'(din_ready), 64'd0);
    chk("midrst_err", 64'(cfg_error), 64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    base = wr_cnt;
    pulse_start(1'b0, 8'h00);
    send_byte(8'hA5);
    send_frames(21);
    send_byte(8'hFF);
    chk("postrst_done", 64'(cfg_done), 64'd1);
    @(posedge clock);
    #1;
    chk("postrst_writes", 64'(wr_cnt - base), 64'd22);

    // Start mid-frame with a simultaneous byte that must be dropped
    base = wr_cnt;
    pulse_start(1'b0, 8'h00);
    send_byte(8'hA5);
    send_frames(3);
    send_byte(8'h04);
    send_byte(fb(4, 0));
    pulse_start(1'b1, 8'hA5);
    chk("mid_start_ready", 64'(din_ready), 64'd1);
    send_byte(8'h00);
    send_byte(8'hA5);
    send_frames(21);
    send_byte(8'hFF);
    chk("mid_start_done", 64'(cfg_done), 64'd1);
    chk("mid_start_err", 64'(cfg_error), 64'd0);
    @(posedge clock);
    #1;
    chk("mid_start_writes", 64'(wr_cnt - base), 64'd26);

    // Restart after all words written must clear the mask
    pulse_start(1'b0, 8'h00);
    send_byte(8'hA5);
    send_frames(21);
    pulse_start(1'b0, 8'h00);
    send_byte(8'hA5);
    send_frames(20);
    send_byte(8'hFF);
    chk("mask_clr_code", 64'(err_code), 64'd3);
    chk("mask_clr_fen", 64'(fabric_en), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cfg_stream_loader.md
# cfg_stream_loader

Configuration loader sitting directly upstream of the fabric top level. It accepts a byte-serial bitstream with a valid/ready handshake, checks framing and per-frame checksums, and writes each logic-tile (33-bit) and switch-box (16-bit) configuration word through a single write port. It asserts `fabric_en` only after every configuration word has been written without error. `fabric_en` gates fabric clocking and outputs.

## Interface
Parameters:
- `NUM_TILES`, 9, logic tiles; addresses `0..NUM_TILES-1`
- `NUM_SB`, 13, switch boxes; addresses `NUM_TILES..NUM_TILES+NUM_SB-1`
- `SYNC_BYTE`, 8'hA5, stream sync marker
- `END_ADDR`, 8'hFF, end-of-stream address

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high
- `start` in 1: one-cycle pulse; begins or restarts a load
- `din` in 8: stream byte
- `din_valid` in 1: `din` valid
- `din_ready` out 1: loader accepts `din`
- `cfg_we` out 1: configuration write strobe
- `cfg_addr` out 5: target tile or switch box
- `cfg_data` out 33: configuration word; switch boxes use `[15:0]`, with `[32:16]`=0
- `cfg_done` out 1: load completed successfully
- `cfg_error` out 1: load aborted, sticky
- `err_code` out 2: 1=bad address, 2=checksum, 3=incomplete
- `fabric_en` out 1: equals `cfg_done`, registered

## Operation
- States:
  - IDLE: entered on reset, `din_ready`=0.
  - SYNC: discard bytes until `SYNC_BYTE`.
  - ADDR
  - DATA
  - CHECK
  - WRITE
  - DONE
  - ERROR
- `start` from any state:
  - go to SYNC
  - clear `cfg_done`, `cfg_error`, `err_code`, and the written-mask (`NUM_TILES+NUM_SB` bits)
- ADDR: accept one byte.
  - `< NUM_TILES`: expect 5 data bytes.
  - Switch-box range: expect 2 data bytes.
  - `END_ADDR`: if mask all-ones go to DONE, else ERROR with code 3.
  - Any other value: ERROR with code 1.
- DATA: bytes arrive LSB first.
  - Tile word is `{b4[0],b3,b2,b1,b0}`; `b4[7:1]` is ignored.
  - Switch-box word is `{b1,b0}`.
- CHECK: accepted byte must equal the XOR of the address byte and all data bytes.
  - Match: go to WRITE.
  - Mismatch: go to ERROR with code 2; nothing is written.
- WRITE: exactly one cycle with `cfg_we`=1, `cfg_addr`/`cfg_data` valid.
  - Set the mask bit, return to ADDR.
  - A repeated address rewrites the word; the mask bit stays set.
- DONE and ERROR hold until `start` or `reset`; `din_ready`=0 in both.

## Timing
- Reset values: every output 0, state IDLE.
- `din_ready`=1 exactly in SYNC, ADDR, DATA and CHECK.
  - Driven combinationally from state.
  - A byte transfers on a rising edge with `din_valid`&&`din_ready`.
- `cfg_we` is registered: it is high in the cycle after the checksum byte transfers, for one cycle.
  - `din_ready`=0 during that cycle.
- `cfg_addr`/`cfg_data` are stable while `cfg_we`=1 and hold their last values otherwise.
- `cfg_done`, `fabric_en` and `cfg_error` rise one cycle after the terminating byte transfers.
- Simultaneous `start` and a byte transfer: `start` wins and the byte is dropped.
- `start` in WRITE suppresses nothing already issued, but the mask is cleared.
- `reset` mid-frame: immediate return to reset values.
  - Any partial word is lost.
  - `cfg_we` falls asynchronously.
- `din_valid` gaps of any length are allowed; state and byte count are held.

## Structure
- Package `cfg_pkg`:
  - state enum `cfg_state_t`
  - `SYNC_BYTE`, `END_ADDR`
  - `TILE_BYTES`=5, `SB_BYTES`=2
  - error-code constants `ERR_ADDR`, `ERR_CSUM`, `ERR_INCOMPLETE`
- Sub-module `cfg_byte_assembler` contains:
  - 40-bit shift register with byte counter
  - running XOR checksum
  - clear and load-enable inputs

  The FSM, mask and outputs stay in the top module.

## Test plan
- Full stream: `start`, noise bytes 00/3C, A5, frames 0..21 with correct checksums, then FF.
  - 22 `cfg_we` pulses.
  - Tile 0 bytes 01 02 03 04 01 give `cfg_data`=33'h1_0403_0201.
  - `cfg_done`=`fabric_en`=1.
- Frame 9 (bytes 34 12) with checksum 00 instead of 2F: no write for address 9, `cfg_error`=1, `err_code`=2, `din_ready`=0.
- Address byte 0x30 after sync: ERROR, `err_code`=1, zero writes.
- Frames 0..20 followed by FF: `err_code`=3, `fabric_en`=0.
- Full stream with `din_valid` toggling every cycle and random 0–3 cycle gaps: same writes in the same order, identical final outputs.
- `reset` asserted mid-tile-frame, then `start`: outputs 0 during reset.
  - A fresh full stream completes with `cfg_done`=1.
- `start` pulsed mid-stream: loading restarts from SYNC.
